uart_reporter: RTL and testbench

Transmit-side UART companion to the boot-time instruction collector. It captures every architectural register writeback (`reg_write`, `write_back_id`, writeback data) from the WB stage into a small FIFO and serializes each event as a fixed 6-byte 8N1 frame on `tx_serial`. A host can therefore trace program execution over the same serial link used to load the program.

---
 rtl/common_pkg.sv | 26 ++
 rtl/uart_reporter_if.sv | 15 +
 rtl/uart_reporter_tx_byte.sv | 77 +++++++
 rtl/uart_reporter.sv | 109 ++++++++++
 tb/tb_uart_reporter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared types and constants for the writeback trace reporter.
// Frame layout: header, id byte, then the 32-bit data little-endian.
package common_pkg;
  localparam logic [7:0] REPORT_HDR         = 8'hA5;
  localparam int         REPORT_FRAME_BYTES = 6;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} uart_byte_state_t;
  typedef enum logic {F_IDLE, F_SEND} frame_state_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } report_entry_t;

  function automatic logic [7:0] frame_byte(report_entry_t e, logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = REPORT_HDR;
      3'd1:    frame_byte = {3'b000, e.id};
      3'd2:    frame_byte = e.data[7:0];
      3'd3:    frame_byte = e.data[15:8];
      3'd4:    frame_byte = e.data[23:16];
      3'd5:    frame_byte = e.data[31:24];
      default: frame_byte = 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/uart_reporter_if.sv
// Writeback capture inputs and UART/status outputs of the reporter.
interface uart_reporter_if;
  logic        enable;
  logic        reg_write;
  logic [4:0]  write_back_id;
  logic [31:0] wb_data;
  logic        tx_serial;
  logic        busy;
  logic        overflow;

  modport master (output enable, reg_write, write_back_id, wb_data,
                  input  tx_serial, busy, overflow);
  modport slave  (input  enable, reg_write, write_back_id, wb_data,
                  output tx_serial, busy, overflow);
endinterface

// File: rtl/uart_reporter_tx_byte.sv
// 8N1 byte transmitter; a byte offered on the stop-bit boundary starts
// immediately so bytes within a frame run back-to-back.
module uart_tx_byte
  import common_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       done,
  output logic       tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_byte_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_tx, w_tx_nxt, w_bit_end, w_load;

  assign w_bit_end = (r_cnt == LAST);
  assign tx        = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= B_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (w_load) begin
        r_sh  <= data;
        r_cnt <= '0;
        r_bit <= '0;
      end else if (r_state != B_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
        if (r_state == B_DATA && w_bit_end) begin
          r_sh  <= r_sh >> 1;
          r_bit <= r_bit + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      B_IDLE:  if (valid) w_state_nxt = B_START;
      B_START: if (w_bit_end) w_state_nxt = B_DATA;
      B_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = B_STOP;
      B_STOP:  if (w_bit_end) w_state_nxt = valid ? B_START : B_IDLE;
      default: w_state_nxt = B_IDLE;
    endcase
  end

  // Line level for the cycle after the edge, so tx comes straight from a flop.
  always_comb begin
    ready    = (r_state == B_IDLE) || (r_state == B_STOP && w_bit_end);
    done     = (r_state == B_STOP) && w_bit_end;
    w_load   = valid && ready;
    w_tx_nxt = 1'b1;
    case (r_state)
      B_IDLE:  w_tx_nxt = !w_load;
      B_START: w_tx_nxt = w_bit_end ? r_sh[0] : 1'b0;
      B_DATA:  w_tx_nxt = w_bit_end ? ((r_bit == 3'd7) ? 1'b1 : r_sh[1]) : r_sh[0];
      B_STOP:  w_tx_nxt = !w_load;
      default: w_tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: rtl/uart_reporter.sv
// Captures register writebacks into a FIFO and streams each one as a
// 6-byte UART frame for host-side execution tracing.
module uart_reporter
  import common_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_reporter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [2:0] LAST_IDX = 3'(REPORT_FRAME_BYTES - 1);

  report_entry_t r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
  logic          w_empty, w_full, w_push_req, w_push, w_pop;
  frame_state_t  r_fstate, w_fstate_nxt;
  report_entry_t r_frame;
  logic [2:0]    r_idx;
  logic          w_tx_valid, w_tx_ready, w_tx_done, w_tx;
  logic [7:0]    w_tx_data;
  logic          r_busy, r_overflow;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push_req = bus.enable && bus.reg_write && (bus.write_back_id != 5'd0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_wr_nxt   = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
  assign w_rd_nxt   = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= report_entry_t'{id: bus.write_back_id, data: bus.wb_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_overflow <= r_overflow | (w_push_req & w_full & ~w_pop);
      r_busy     <= (w_wr_nxt != w_rd_nxt) || (w_fstate_nxt == F_SEND);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstate <= F_IDLE;
      r_frame  <= '0;
      r_idx    <= '0;
    end else begin
      r_fstate <= w_fstate_nxt;
      if (w_pop) begin
        r_frame <= r_mem[r_rd_ptr[AW-1:0]];
        r_idx   <= '0;
      end else if (r_fstate == F_SEND && w_tx_done) begin
        r_idx   <= r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    case (r_fstate)
      F_IDLE:  if (!w_empty && w_tx_ready) w_fstate_nxt = F_SEND;
      F_SEND:  if (w_tx_done && r_idx == LAST_IDX) w_fstate_nxt = F_IDLE;
      default: w_fstate_nxt = F_IDLE;
    endcase
  end

  // The header is constant, so it can be offered before the entry is popped.
  always_comb begin
    w_pop      = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_data  = REPORT_HDR;
    case (r_fstate)
      F_IDLE: begin
        w_pop      = !w_empty && w_tx_ready;
        w_tx_valid = !w_empty;
      end
      F_SEND: begin
        w_tx_valid = (r_idx != LAST_IDX);
        w_tx_data  = frame_byte(r_frame, r_idx + 3'd1);
      end
      default: ;
    endcase
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (w_tx_data),
    .valid (w_tx_valid),
    .ready (w_tx_ready),
    .done  (w_tx_done),
    .tx    (w_tx)
  );

  assign bus.tx_serial = w_tx;
  assign bus.busy      = r_busy;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_uart_reporter.sv
// Bench for uart_reporter: timing-level model of captures and frame slots,
// a mid-bit sampling UART receiver as monitor, and a frame scoreboard.
module tb_uart_reporter;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 60 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reporter_if bus();
  uart_reporter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  bit chk_on = 1'b0;

  typedef struct { logic [4:0] id; logic [31:0] data; int start; } exp_t;
  exp_t expq[$];
  int   pushq[$];
  int   popq[$];
  int   last_pop = -100000;
  int   ovf_at = -1;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    expq.delete(); pushq.delete(); popq.delete();
    last_pop = -100000;
    ovf_at   = -1;
  endtask

  // Event captured at edge t; a frame takes FRAME cycles plus one idle cycle
  // before the next pop, and an entry occupies the FIFO until its pop edge.
  task automatic drive(bit en, bit rw, logic [4:0] id, logic [31:0] d);
    int t, held, p;
    @(negedge clk);
    bus.enable = en; bus.reg_write = rw; bus.write_back_id = id; bus.wb_data = d;
    t = cyc + 1;
    if (en && rw && id != 5'd0) begin
      held = 0;
      foreach (popq[i]) if (popq[i] > t) held++;
      if (held < DEPTH) begin
        p = (t + 1 > last_pop + FRAME + 1) ? t + 1 : last_pop + FRAME + 1;
        last_pop = p;
        pushq.push_back(t); popq.push_back(p);
        expq.push_back('{id, d, p});
      end else if (ovf_at < 0) begin
        ovf_at = t;
      end
    end
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= last_pop + FRAME + 4 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      n_chk++;
      $display("FAIL wait_idle: timeout at cyc %0d, required idle by %0d", cyc, last_pop + FRAME);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit model_busy(int k);
    model_busy = 1'b0;
    foreach (pushq[i]) if (pushq[i] <= k && k < popq[i] + FRAME) model_busy = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("busy", bus.busy, model_busy(cyc));
      chk("overflow", bus.overflow, (ovf_at >= 0 && cyc >= ovf_at));
    end
  end

  // Receiver: once a start bit is seen, take one sample per cycle for a whole
  // frame; mid-bit samples give the data, the other three must agree with it.
  int   m_st;
  bit   m_abort;
  logic m_smp [FRAME];

  task automatic check_frame();
    exp_t e;
    int bad_w, bad_f;
    logic [47:0] got, ex;
    if (expq.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_frame: start at cyc %0d, expected no frame", m_st);
      return;
    end
    e = expq.pop_front();
    bad_w = 0; bad_f = 0; got = '0;
    for (int b = 0; b < 60; b++)
      for (int k = 1; k < CPB; k++)
        if (m_smp[CPB*b+k] !== m_smp[CPB*b]) bad_w++;
    for (int k = 0; k < 6; k++) begin
      if (m_smp[40*k+2]  !== 1'b0) bad_f++;
      if (m_smp[40*k+38] !== 1'b1) bad_f++;
      for (int j = 0; j < 8; j++) got[8*k+j] = m_smp[40*k + 4*(j+1) + 2];
    end
    ex = {e.data, 3'b000, e.id, 8'hA5};
    chk("start_cycle", m_st, e.start);
    chk("bit_width", bad_w, 0);
    chk("framing", bad_f, 0);
    chk("frame_bytes", got, ex);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_serial === 1'b0) begin
        m_st = cyc;
        m_abort = 1'b0;
        m_smp[0] = bus.tx_serial;
        for (int i = 1; i < FRAME && !m_abort; i++) begin
          @(negedge clk);
          if (rst) m_abort = 1'b1;
          else m_smp[i] = bus.tx_serial;
        end
        if (!m_abort) check_frame();
      end
    end
  end

  initial begin : stim
    int p, target, gap;
    bus.enable = 1'b0; bus.reg_write = 1'b0; bus.write_back_id = '0; bus.wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx_serial, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // single event
    drive(1, 1, 5'd5, 32'h12345678);
    release_bus();
    wait_idle();
    chk("single_idle_busy", bus.busy, 0);

    // ignored captures: id 0, then enable low
    drive(1, 1, 5'd0, 32'hDEADBEEF);
    release_bus();
    drive(0, 1, 5'd7, 32'hCAFEF00D);
    release_bus();
    repeat (300) @(negedge clk);
    chk("ignored_tx", bus.tx_serial, 1);

    // burst of six; enable drops while the queue drains
    bus.enable = 1'b1;
    for (int i = 1; i <= 6; i++) drive(1, 1, 5'(i), i * 32'h01010101);
    release_bus();
    bus.enable = 1'b0;
    wait_idle();
    chk("burst_overflow", bus.overflow, 1);

    // push while full on the edge that pops the next head
    pulse_reset();
    for (int i = 0; i < 5; i++) drive(1, 1, 5'(11 + i), $urandom);
    release_bus();
    target = popq[1];
    while (cyc < target - 2) @(negedge clk);
    drive(1, 1, 5'd20, 32'hA1B2C3D4);
    release_bus();
    wait_idle();
    chk("boundary_overflow", bus.overflow, 0);

    // async reset in the middle of frame byte 3
    pulse_reset();
    drive(1, 1, 5'd9, 32'h00000000);
    release_bus();
    p = popq[0];
    while (cyc < p + 135) @(negedge clk);
    chk("pre_rst_low", bus.tx_serial, 0);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_tx", bus.tx_serial, 1);
    chk("rst_async_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("post_rst_quiet", bus.tx_serial, 1);
    drive(1, 1, 5'd10, 32'h89ABCDEF);
    release_bus();
    wait_idle();

    // random events
    for (int n = 0; n < 20; n++) begin
      drive($urandom_range(0, 7) != 0, 1, 5'($urandom_range(0, 31)), $urandom);
      release_bus();
      gap = $urandom_range(0, 300);
      repeat (gap) @(negedge clk);
    end
    wait_idle();
    chk("scoreboard_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
